// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared encodings for the multicycle MIPS main controller:
//                state codes, opcodes, funct codes, ALU operation codes and
//                the control-strobe bundle driven to the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Controller state encodings (also visible on the debug port)
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_ILLEGAL = 4'd15;

    // Opcodes, IR[31:26]
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Funct codes, IR[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand selects
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Every strobe and select the controller drives to the datapath
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_src;
        logic       branch;
        logic       pc_write;
        logic [2:0] alu_op;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    // States whose exit completes an instruction
    function automatic logic is_final_state(input logic [3:0] st);
        return (st == S_MEMWB)  || (st == S_MEMWR)  || (st == S_ALUWB) ||
               (st == S_BRANCH) || (st == S_ADDIWB) || (st == S_JUMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_func_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_func_decode
//  Description : Combinational R-type funct decode to ALU operation code,
//                with a valid flag for recognised funct values.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_func_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_func,
    output logic [2:0] o_aluop,
    output logic       o_valid
);

    // Map funct to ALU op; unknown funct reports invalid with a benign op
    always_comb begin
        o_aluop = ALU_AND;
        o_valid = 1'b1;
        case (i_func)
            FN_ADD:  o_aluop = ALU_ADD;
            FN_SUB:  o_aluop = ALU_SUB;
            FN_AND:  o_aluop = ALU_AND;
            FN_OR:   o_aluop = ALU_OR;
            FN_SLT:  o_aluop = ALU_SLT;
            default: o_valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_fsm
//  Description : Multicycle MIPS main controller. Moore decode of the state
//                register onto datapath strobes, retired-instruction counter
//                and sticky illegal-instruction halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int RET_W = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [5:0]       OP,
    input  logic [5:0]       Func,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             PCSrc,
    output logic             Branch,
    output logic             PCWrite,
    output logic [2:0]       AluOP,
    output logic             jump,
    output logic             illegal,
    output logic [RET_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [RET_W-1:0] r_retired;
    logic [2:0]       w_func_aluop;
    logic             w_func_valid;
    ctrl_t            w_ctrl;
    ctrl_t            w_out;

    alu_func_decode u_func_dec (
        .i_func  (Func),
        .o_aluop (w_func_aluop),
        .o_valid (w_func_valid)
    );

    // State register; reset parks the controller in FETCH
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Count each instruction as its final state hands back to FETCH
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
        end else if (is_final_state(r_state)) begin
            r_retired <= r_retired + RET_W'(1);
        end
    end

    // Next-state sequencing; anything unrecognised halts in ILLEGAL
    always_comb begin
        w_next = S_ILLEGAL;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                case (OP)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            // OP is held from the IR, so only lw/sw can reach here normally
            S_MEMADR: begin
                if (OP == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (OP == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_ILLEGAL;
                end
            end
            S_MEMRD:   w_next = S_MEMWB;
            S_EXECUTE: w_next = w_func_valid ? S_ALUWB : S_ILLEGAL;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                       w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ILLEGAL: w_next = S_ILLEGAL;
            default:   w_next = S_ILLEGAL;
        endcase
    end

    // Moore strobe decode; only EXECUTE looks at Func for the ALU op
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.ir_write  = 1'b1;
                w_ctrl.alu_src_b = SRCB_ONE;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                w_ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = w_func_aluop;
            end
            S_ALUWB: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.pc_src    = 1'b1;
                w_ctrl.branch    = 1'b1;
            end
            S_ADDIWB: begin
                w_ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.pc_write = 1'b1;
                w_ctrl.jump     = 1'b1;
            end
            S_ILLEGAL: begin
                w_ctrl.illegal = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    // Reset low silences every strobe at once, without waiting for a clock
    always_comb begin
        w_out = reset ? w_ctrl : '0;
    end

    assign IorD      = w_out.iord;
    assign MemWrite  = w_out.mem_write;
    assign IRWrite   = w_out.ir_write;
    assign RegDst    = w_out.reg_dst;
    assign MemtoReg  = w_out.mem_to_reg;
    assign RegWrite  = w_out.reg_write;
    assign ALUSrcA   = w_out.alu_src_a;
    assign ALUSrcB   = w_out.alu_src_b;
    assign PCSrc     = w_out.pc_src;
    assign Branch    = w_out.branch;
    assign PCWrite   = w_out.pc_write;
    assign AluOP     = w_out.alu_op;
    assign jump      = w_out.jump;
    assign illegal   = w_out.illegal;
    assign retired   = r_retired;
    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main controller: the stage directly upstream of the multicycle datapath.
- Consumes the opcode and funct fields from the instruction register.
- Each cycle, drives every datapath control strobe (write enables, mux selects, ALU operation, PC update).
- Sequences one instruction over 3–5 cycles; also provides a retired-instruction counter and a sticky illegal-instruction halt.

Parameters:
- RET_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OP  in  6  opcode, IR[31:26].
- Func  in  6  funct, IR[5:0].
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  destination register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  write-back select: 0 = ALUOut, 1 = data register.
- RegWrite  out  1  register-file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = constant 1, 10 = sign-extended imm, 11 = imm<<2.
- PCSrc  out  1  next-PC source: 0 = ALU result, 1 = ALUOut.
- Branch  out  1  conditional PC write (qualified by zero in the datapath).
- PCWrite  out  1  unconditional PC write.
- AluOP  out  3  ALU operation code.
- jump  out  1  selects jump target in next-PC logic.
- illegal  out  1  sticky: undecodable OP or Func seen.
- retired  out  RET_W  count of completed instructions.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset: async, active-low. While reset = 0: state = FETCH, retired = 0, illegal = 0, and all strobes/selects forced to 0, overriding the state decode. The first cycle after release is FETCH.
- Outputs are Moore: combinational decode of the state register. The exception is AluOP in EXECUTE, which also decodes Func. All outputs not listed for a state are 0.
- Memory is word-addressed, so PC increments by 1 and the branch offset is the sign-extended immediate without shift.
- States and actions:
  - FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, AluOP=ADD, PCSrc=0, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=10, AluOP=ADD (branch target into ALUOut). Next by OP:
    - lw/sw -> MEMADR
    - R -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - else -> ILLEGAL
  - MEMADR: ALUSrcA=1, ALUSrcB=10, AluOP=ADD. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD: IorD=1. Next: MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR: IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, AluOP=f(Func). Next: ALUWB, or ILLEGAL if Func is undefined.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, AluOP=SUB, PCSrc=1, Branch=1. Next: FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, AluOP=ADD. Next: ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - JUMP: PCWrite=1, jump=1. Next: FETCH.
  - ILLEGAL: all strobes 0, illegal=1. Self-loop; only reset exits.
- Latency: lw 5 cycles; sw, R, addi 4; beq, j 3.
- retired increments by 1 on the cycle leaving a final state (MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP) into FETCH. Wraps modulo 2^RET_W. Never increments in ILLEGAL.
- Func with OP ≠ R-type is ignored.
- Reset asserted mid-instruction aborts immediately with no partial strobes; no instruction is counted.
- Unreachable state encodings go to ILLEGAL.

Decomposition:
- Package mc_ctrl_pkg:
  - State enumeration, 4-bit: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=15.
  - Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
  - Funct codes: ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010.
  - AluOP codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- Sub-module alu_func_decode: combinational Func -> {AluOP, valid}. The FSM itself stays in the top module.

Test Plan:
- Release reset, OP=100011 held -> states 0,1,2,3,4,0. IRWrite=1 and PCWrite=1 only in cycle 1. MemtoReg=1 and RegWrite=1 in cycle 5. retired=1.
- OP=000000, Func=100010 -> EXECUTE shows ALUSrcA=1, ALUSrcB=00, AluOP=110. ALUWB shows RegDst=1, RegWrite=1. Total 4 cycles.
- OP=000100 -> BRANCH shows Branch=1, PCSrc=1, AluOP=110, PCWrite=0. Return to FETCH after 3 cycles.
- OP=000010 then OP=101011 back-to-back -> JUMP shows jump=1, PCWrite=1. Then MEMWR shows MemWrite=1, IorD=1. retired=2 after 7 cycles.
- OP=111111 -> DECODE then ILLEGAL. illegal=1 and all strobes 0 for 20+ cycles. reset low releases to FETCH with illegal=0.
- Assert reset in MEMRD of a lw -> outputs 0 immediately (asynchronously). retired unchanged at 0. Next cycle after release is FETCH.
